lsu_multi_seq: RTL
==================

Name: lsu_multi_seq

Overview:
Parametrised multicycle load/store sequencer between the multicycle datapath's memory stage and a variable-latency data bus with valid/ack handshake. It replaces single-cycle combinational load/store alignment and adds several capabilities:
- wait states
- byte-lane steering
- sign/zero extension
- bus timeout
- optional splitting of misaligned accesses into two bus beats
The datapath issues one request, stalls, and resumes on a one-cycle done pulse.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes.
ADDR_W, 32, address width.
TIMEOUT_CYC, 255, max cycles a beat waits for iBusAck before aborting; 8-bit counter minimum, width $clog2(TIMEOUT_CYC+1).

Ports:
iCLK  in  1  clock, rising edge.
iRST_N  in  1  asynchronous active-low reset.
iReq  in  1  request strobe; sampled only when oReady=1.
oReady  out  1  high only in IDLE.
iWe  in  1  1=store, 0=load.
iFunct3  in  3  RISC-V funct3 (size/sign).
iAddr  in  ADDR_W  byte address.
iWData  in  XLEN  store data, right-aligned.
oDone  out  1  one-cycle pulse, access finished (ok or error).
oRData  out  XLEN  extended load data; valid with oDone, held until next accept.
oExc  out  2  with oDone: 0 ok, 1 misaligned, 2 bus timeout, 3 illegal funct3.
oBusAddr  out  ADDR_W  NB-aligned beat address.
oBusWData  out  XLEN  lane-steered store data.
oBusBE  out  NB  byte enables.
oBusWE  out  1  write valid.
oBusRE  out  1  read valid.
iBusAck  in  1  beat completes in the cycle it is high while a valid is high.
iBusRData  in  XLEN  read data, sampled on ack.

Behaviour:
- Reset (async, iRST_N=0): state IDLE. oReady=1. oDone=0, oExc=0, oRData=0. All bus outputs 0. Timeout counter 0. Reset mid-beat drops the beat silently; no oDone.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on iReq, latch iWe, iFunct3, iAddr and iWData, and decode size.
  - Illegal funct3 → RESP with oExc=3: 011/110 when XLEN=32; any store funct3 ≥ 100; 111.
  - Misaligned (addr not multiple of size) without the feature → RESP with oExc=1, no bus activity.
  - Otherwise → BEAT0.
- BEAT0/BEAT1: assert oBusRE or oBusWE with stable address, BE and data until iBusAck.
  - Counter increments each non-ack cycle; reaching TIMEOUT_CYC → deassert valid, RESP with oExc=2.
  - Ack in BEAT0 → BEAT1 if split, else RESP. Ack in BEAT1 → RESP.
  - Counter clears on each beat entry.
- Lane steering: offset = addr mod NB; BE = size mask << offset (truncated to NB for beat0); oBusWData = wdata << 8*offset. Beat1 address = beat0 address + NB; BE = overflow bits of the mask; data = wdata >> 8*(NB-offset).
- Loads: selected bytes are collected and right-justified, merging beat1 bytes above beat0 bytes. Sign-extend for LB/LH/LW (LW only when XLEN=64); zero-extend for LBU/LHU/LWU; LD/LW-at-XLEN is the full width.
- RESP: oDone=1 for exactly one cycle, oRData/oExc updated, then IDLE. oReady rises the cycle after oDone.
- Latency, aligned, ack in first valid cycle: accept at cycle 0, valid at cycle 1, oDone at cycle 2. Each wait state adds 1 cycle; a split adds ≥1 cycle.
- Bus valids are never asserted in IDLE or RESP. iBusAck outside BEAT0/BEAT1 is ignored.
- Stores write no oRData; it holds its previous value.

Optional Feature:
LSU_SPLIT_MISALIGNED_EN:
- Defined: misaligned accesses run as BEAT0+BEAT1 per the steering rules, oExc=0. A timeout in BEAT1 reports 2; beat0 store bytes stay committed, with no rollback.
- Undefined: BEAT1 logic is not built, and misaligned accesses return oExc=1 without any bus cycle.

Decomposition:
Shared package lsu_pkg holds:
- state enum
- oExc codes
- funct3 constants (LB..LWU, SB/SH/SW/SD)
- the size-decode function

One natural sub-module: lsu_lane_align. It is combinational and provides:
- BE/data shift for stores
- byte select, merge and extension for loads
FSM, counter and latches stay in the top.

Test Plan:
- XLEN=32, LW 0x1000, ack on first valid cycle, RData 0xDEADBEEF → BE=1111, oDone at cycle 2, oRData=0xDEADBEEF, oExc=0.
- LB 0x1003, bus data 0x80123456 → BE=1000, oRData=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0x1002, wdata 0x0000BEEF, 3 wait states → oBusWE held 4 cycles, BE=1100, oBusWData=0xBEEF0000, oDone at cycle 5.
- LW 0x1003, beats return 0xAA000000 then 0x00CCBBDD:
  - With macro: beat0 addr 0x1000 BE=1000, beat1 addr 0x1004 BE=0111, oRData=0xCCBBDDAA.
  - Without macro: oExc=1, no valid ever asserted.
- No ack for TIMEOUT_CYC=4 cycles → valid drops, oDone with oExc=2. Funct3=011 at XLEN=32 → oExc=3.
- iRST_N pulled low during BEAT0 → bus valids 0 immediately, oReady=1, no oDone. A new request after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, exception codes, funct3 constants and size decode for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_e;

    typedef enum logic [1:0] {
        EXC_OK       = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2,
        EXC_ILLEGAL  = 2'd3
    } lsu_exc_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef struct packed {
        logic       illegal;
        logic [1:0] size;    // log2 of access size in bytes
    } lsu_dec_t;

    function automatic lsu_dec_t size_decode(input logic we, input logic [2:0] f3,
                                             input logic xlen64);
        lsu_dec_t d;
        d.size    = f3[1:0];
        d.illegal = (f3 == 3'b111) || (we && f3[2]) ||
                    (!xlen64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
        return d;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for stores and byte select/merge/extension for loads.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0] off,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata0,
    input  logic [XLEN-1:0] rdata1,
    output logic [NB-1:0]   be0,
    output logic [NB-1:0]   be1,
    output logic [XLEN-1:0] wdata0,
    output logic [XLEN-1:0] wdata1,
    output logic [XLEN-1:0] rdata_ext
);

    logic [NB-1:0]     mask;
    logic [2*NB-1:0]   mask2;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   raw;
    logic              sb;
    int                nbits;
    int                sh1;

    always_comb begin
        case (size)
            2'd0:    mask = NB'(4'h1);
            2'd1:    mask = NB'(4'h3);
            2'd2:    mask = NB'(4'hF);
            default: mask = '1;
        endcase
        mask2 = {{NB{1'b0}}, mask} << off;
        be0   = mask2[NB-1:0];
        be1   = mask2[2*NB-1:NB];
    end

    // Beat1 carries whatever shifted past the top lane of beat0.
    always_comb begin
        sh1    = XLEN - 8 * int'(off);
        wdata0 = wdata << {off, 3'b000};
        wdata1 = wdata >> sh1;
    end

    always_comb begin
        cat = {rdata1, rdata0} >> {off, 3'b000};
        raw = cat[XLEN-1:0];
        case (size)
            2'd0:    sb = raw[7];
            2'd1:    sb = raw[15];
            2'd2:    sb = raw[31];
            default: sb = raw[XLEN-1];
        endcase
        if (uns) sb = 1'b0;
        nbits = 8 << size;
        for (int i = 0; i < XLEN; i++)
            rdata_ext[i] = (i < nbits) ? raw[i] : sb;
    end

endmodule

// File: rtl/lsu_multi_seq.sv
// Multicycle load/store sequencer: request latch, beat FSM, timeout and response.
// Define LSU_SPLIT_MISALIGNED_EN to split lane-crossing misaligned accesses into two beats.
module lsu_multi_seq
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iReq,
    output logic              oReady,
    input  logic              iWe,
    input  logic [2:0]        iFunct3,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [XLEN-1:0]   iWData,
    output logic              oDone,
    output logic [XLEN-1:0]   oRData,
    output logic [1:0]        oExc,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [XLEN-1:0]   oBusWData,
    output logic [XLEN/8-1:0] oBusBE,
    output logic              oBusWE,
    output logic              oBusRE,
    input  logic              iBusAck,
    input  logic [XLEN-1:0]   iBusRData
);

    localparam int NB     = XLEN / 8;
    localparam int OFFW   = $clog2(NB);
    localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W  = (CW_RAW < 8) ? 8 : CW_RAW;

    lsu_state_e        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    lsu_dec_t          dec;
    logic [2:0]        szm;
    logic              mis;
    logic              in_beat;
    logic [ADDR_W-1:0] base;
    logic [XLEN-1:0]   rd0_in;
    logic [NB-1:0]     be0, be1;
    logic [XLEN-1:0]   wd0, wd1, ld_data;

`ifdef LSU_SPLIT_MISALIGNED_EN
    logic              split_q;
    logic [XLEN-1:0]   rd0_q;
    logic [OFFW:0]     span;
`endif

    always_comb begin
        dec = size_decode(iWe, iFunct3, XLEN == 64);
        case (dec.size)
            2'd0:    szm = 3'd0;
            2'd1:    szm = 3'd1;
            2'd2:    szm = 3'd3;
            default: szm = 3'd7;
        endcase
        mis = (iAddr[OFFW-1:0] & szm[OFFW-1:0]) != '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
        // Carry out of offset + (bytes-1) means the access crosses into the next beat.
        span = {1'b0, iAddr[OFFW-1:0]} + {1'b0, szm[OFFW-1:0]};
`endif
    end

`ifdef LSU_SPLIT_MISALIGNED_EN
    assign rd0_in = (state == BEAT1) ? rd0_q : iBusRData;
`else
    assign rd0_in = iBusRData;
`endif

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .off       (addr_q[OFFW-1:0]),
        .size      (f3_q[1:0]),
        .uns       (f3_q[2]),
        .wdata     (wdata_q),
        .rdata0    (rd0_in),
        .rdata1    (iBusRData),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wd0),
        .wdata1    (wd1),
        .rdata_ext (ld_data)
    );

    // Bus side is decoded from registered state so reset drops valids immediately.
    assign in_beat   = (state == BEAT0) || (state == BEAT1);
    assign base      = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign oReady    = (state == IDLE);
    assign oBusRE    = in_beat && !we_q;
    assign oBusWE    = in_beat && we_q;
    assign oBusAddr  = !in_beat ? '0 : (state == BEAT1) ? base + ADDR_W'(NB) : base;
    assign oBusBE    = !in_beat ? '0 : (state == BEAT1) ? be1 : be0;
    assign oBusWData = !in_beat ? '0 : (state == BEAT1) ? wd1 : wd0;
    assign cnt_nxt   = cnt + 1'b1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            oDone   <= 1'b0;
            oExc    <= EXC_OK;
            oRData  <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
            split_q <= 1'b0;
            rd0_q   <= '0;
`endif
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: if (iReq) begin
                    we_q    <= iWe;
                    f3_q    <= iFunct3;
                    addr_q  <= iAddr;
                    wdata_q <= iWData;
                    cnt     <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
                    split_q <= span[OFFW];
`endif
                    if (dec.illegal) begin
                        state <= RESP;
                        oDone <= 1'b1;
                        oExc  <= EXC_ILLEGAL;
                    end else if (mis) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
                        state <= BEAT0;
`else
                        state <= RESP;
                        oDone <= 1'b1;
                        oExc  <= EXC_MISALIGN;
`endif
                    end else begin
                        state <= BEAT0;
                    end
                end
                BEAT0, BEAT1: begin
                    if (iBusAck) begin
                        cnt <= '0;
`ifdef LSU_SPLIT_MISALIGNED_EN
                        rd0_q <= iBusRData;
                        if (state == BEAT0 && split_q) begin
                            state <= BEAT1;
                        end else begin
                            state <= RESP;
                            oDone <= 1'b1;
                            oExc  <= EXC_OK;
                            if (!we_q) oRData <= ld_data;
                        end
`else
                        state <= RESP;
                        oDone <= 1'b1;
                        oExc  <= EXC_OK;
                        if (!we_q) oRData <= ld_data;
`endif
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
                            state <= RESP;
                            oDone <= 1'b1;
                            oExc  <= EXC_TIMEOUT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
